// File: rtl/dds_pkg.sv
// Shared definitions for the DDS start sequencer.
// State codes are exported on state_o for debug LEDs.
package dds_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_SETTLE  = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_DAC_REQ = 3'd2,
        ST_LOCK    = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dds_seq_counter.sv
// Saturating up-counter with clear, load, enable and terminal-count flag.
// Clear has priority over load, and load has priority over enable.
module dds_seq_counter #(
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge sysclk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/dds_start_sequencer.sv
// Power-up sequencer: settle, accumulator clear, DAC init handshake,
// PLL lock qualification, then run. Wait-stage timeouts latch a fault.
module dds_start_sequencer
    import dds_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int CLR_CYCLES    = 16,
    parameter int LOCK_STABLE   = 256,
    parameter int TIMEOUT       = 65535
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       dac_init_ack,
    input  logic       pll_locked,
    input  logic       retry,
    output logic       acc_clr,
    output logic       dac_init_req,
    output logic       run_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int CNT_MAX = max2(max2(SETTLE_CYCLES, CLR_CYCLES),
                                  max2(LOCK_STABLE, TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] stg_cnt;
    logic [CNT_W-1:0] stg_term;
    logic             stg_tc;
    logic             stg_clr;
    logic [CNT_W-1:0] lk_cnt;
    logic             lk_tc;
    logic             lk_clr;
    logic             lock_qual;

    // Stage counter doubles as the timeout counter in DAC_REQ and LOCK
    always_comb begin
        stg_term = '1;
        case (state)
            ST_SETTLE:  stg_term = CNT_W'(SETTLE_CYCLES - 1);
            ST_CLEAR:   stg_term = CNT_W'(CLR_CYCLES - 1);
            ST_DAC_REQ: stg_term = CNT_W'(TIMEOUT - 1);
            ST_LOCK:    stg_term = CNT_W'(TIMEOUT - 1);
            default:    stg_term = '1;
        endcase
    end

    assign stg_clr   = (state_next != state);
    assign lk_clr    = (state != ST_LOCK) || !pll_locked;
    assign lock_qual = pll_locked && lk_tc;

    dds_seq_counter #(.WIDTH(CNT_W)) u_stage_cnt (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .clr      (stg_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (1'b1),
        .term     (stg_term),
        .cnt      (stg_cnt),
        .tc       (stg_tc)
    );

    dds_seq_counter #(.WIDTH(CNT_W)) u_lock_cnt (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .clr      (lk_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (1'b1),
        .term     (CNT_W'(LOCK_STABLE - 1)),
        .cnt      (lk_cnt),
        .tc       (lk_tc)
    );

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack beats DAC timeout; qualification beats lock timeout
    always_comb begin
        state_next = state;
        case (state)
            ST_SETTLE: begin
                if (stg_tc) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (stg_tc) state_next = ST_DAC_REQ;
            end
            ST_DAC_REQ: begin
                if (dac_init_ack)  state_next = ST_LOCK;
                else if (stg_tc)   state_next = ST_FAULT;
            end
            ST_LOCK: begin
                if (lock_qual)     state_next = ST_RUN;
                else if (stg_tc)   state_next = ST_FAULT;
            end
            ST_RUN: begin
                if (!pll_locked)   state_next = ST_LOCK;
            end
            ST_FAULT: begin
                if (retry)         state_next = ST_SETTLE;
            end
            default: state_next = ST_SETTLE;
        endcase
    end

    assign acc_clr      = (state == ST_CLEAR);
    assign dac_init_req = (state == ST_DAC_REQ);
    assign run_en       = (state == ST_RUN);
    assign ready        = (state == ST_RUN);
    assign fault        = (state == ST_FAULT);
    assign state_o      = state;

    logic unused_cnt;
    assign unused_cnt = ^{stg_cnt, lk_cnt};

endmodule

// File: tb/tb_dds_start_sequencer.sv
// Scoreboard bench for dds_start_sequencer with short sequence parameters.
module tb_dds_start_sequencer;
    import dds_pkg::*;

    logic       sysclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dac_init_ack = 1'b0;
    logic       pll_locked = 1'b0;
    logic       retry = 1'b0;
    logic       acc_clr;
    logic       dac_init_req;
    logic       run_en;
    logic       ready;
    logic       fault;
    logic [2:0] state_o;

    logic [7:0] sb_q[$];
    int         tests = 0;
    int         failed = 0;
    int         chk_no = 0;

    always #5 sysclk = ~sysclk;

    dds_start_sequencer #(
        .SETTLE_CYCLES (8),
        .CLR_CYCLES    (4),
        .LOCK_STABLE   (5),
        .TIMEOUT       (16)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .dac_init_ack (dac_init_ack),
        .pll_locked   (pll_locked),
        .retry        (retry),
        .acc_clr      (acc_clr),
        .dac_init_req (dac_init_req),
        .run_en       (run_en),
        .ready        (ready),
        .fault        (fault),
        .state_o      (state_o)
    );

    localparam logic [2:0] S = 3'd0;
    localparam logic [2:0] C = 3'd1;
    localparam logic [2:0] D = 3'd2;
    localparam logic [2:0] L = 3'd3;
    localparam logic [2:0] R = 3'd4;
    localparam logic [2:0] F = 3'd5;

    // {state_o, acc_clr, dac_init_req, run_en, ready, fault}
    function automatic logic [7:0] expv(input logic [2:0] s);
        return {s, s == C, s == D, s == R, s == R, s == F};
    endfunction

    // Expect state s for the current cycle; inputs apply at the next edge
    task automatic cyc(input logic [2:0] s, input logic a, input logic p,
                       input logic r, input logic rn);
        @(posedge sysclk);
        #1;
        dac_init_ack = a;
        pll_locked   = p;
        retry        = r;
        reset_n      = rn;
        sb_q.push_back(expv(s));
    endtask

    task automatic rep(input int n, input logic [2:0] s, input logic a,
                       input logic p, input logic r, input logic rn);
        for (int i = 0; i < n; i++) cyc(s, a, p, r, rn);
    endtask

    always @(negedge sysclk) begin
        if (sb_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] g;
            e = sb_q.pop_front();
            g = {state_o, acc_clr, dac_init_req, run_en, ready, fault};
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL chk%0d outputs got=%b exp=%b", chk_no, g, e);
            end
            chk_no++;
        end
    end

    initial begin
        repeat (2) @(posedge sysclk);

        // Nominal bring-up, then lock loss in RUN
        cyc(S, 0, 1, 0, 1);
        rep(7, S, 0, 1, 0, 1);
        rep(4, C, 0, 1, 0, 1);
        rep(2, D, 0, 1, 0, 1);
        cyc(D, 1, 1, 0, 1);
        rep(5, L, 0, 1, 0, 1);
        rep(10, R, 0, 1, 0, 1);
        cyc(R, 0, 0, 0, 1);
        rep(5, L, 0, 1, 0, 1);
        rep(4, R, 0, 1, 0, 1);
        cyc(R, 0, 1, 0, 0);

        // Reset in RUN, then reset mid-CLEAR
        cyc(S, 0, 1, 0, 1);
        rep(7, S, 0, 1, 0, 1);
        cyc(C, 0, 1, 0, 1);
        cyc(C, 0, 1, 0, 0);

        // No ack: DAC timeout, fault, retry
        cyc(S, 0, 1, 0, 1);
        rep(7, S, 0, 1, 0, 1);
        rep(4, C, 0, 1, 0, 1);
        rep(16, D, 0, 1, 0, 1);
        rep(7, F, 0, 1, 0, 1);
        cyc(F, 0, 1, 1, 1);

        // Re-sequence with lock glitch
        rep(8, S, 0, 1, 0, 1);
        rep(4, C, 0, 1, 0, 1);
        cyc(D, 0, 1, 0, 1);
        cyc(D, 1, 1, 0, 1);
        rep(3, L, 0, 1, 0, 1);
        cyc(L, 0, 0, 0, 1);
        rep(5, L, 0, 1, 0, 1);
        rep(2, R, 0, 1, 0, 1);
        cyc(R, 0, 0, 0, 1);

        // Qualification on the timeout cycle wins
        rep(11, L, 0, 0, 0, 1);
        rep(5, L, 0, 1, 0, 1);
        cyc(R, 0, 0, 0, 1);

        // Lock timeout, retry held off, reset out of FAULT
        rep(16, L, 0, 0, 0, 1);
        cyc(F, 0, 0, 0, 1);
        cyc(F, 0, 0, 0, 0);

        // Ack held from reset, retry pulses outside FAULT
        cyc(S, 1, 1, 1, 1);
        rep(7, S, 1, 1, 0, 1);
        cyc(C, 1, 1, 1, 1);
        rep(3, C, 1, 1, 0, 1);
        cyc(D, 1, 1, 1, 1);
        rep(5, L, 1, 1, 0, 1);
        cyc(R, 1, 1, 1, 1);
        cyc(R, 1, 1, 0, 0);

        // Ack on the DAC timeout cycle wins
        cyc(S, 0, 1, 0, 1);
        rep(7, S, 0, 1, 0, 1);
        rep(4, C, 0, 1, 0, 1);
        rep(15, D, 0, 1, 0, 1);
        cyc(D, 1, 1, 0, 1);
        rep(5, L, 0, 1, 0, 1);
        rep(2, R, 0, 1, 0, 1);

        @(negedge sysclk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
